// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder, MSB first. All SPI pins are oversampled in the Mclk
// domain; spi_clk is never used as a clock.
module spi_slave_rx #(
  parameter int DSIZE = 8,
  parameter int CNT_W = 4
) (
  input  logic             Mclk,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             spi_cs,
  input  logic             spi_mosi_in,
  output logic             spi_miso_out,
  output logic             spi_miso_oe,
  input  logic [DSIZE-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [DSIZE-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       sclk_sync_q;
  logic [2:0]       cs_sync_q;
  logic [1:0]       mosi_sync_q;

  logic [DSIZE-1:0] tx_buf_q, tx_buf_d;
  logic             tx_full_q, tx_full_d;
  logic [DSIZE-1:0] tx_shift_q, tx_shift_d;
  logic [DSIZE-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             rx_done_q, rx_done_d;
  logic [DSIZE-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_underrun_q, tx_underrun_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic word_load, tx_accept;

  // cs synchronizer resets to the deselected level so release never fakes a cs_fall.
  always_ff @(posedge Mclk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_in};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  always_ff @(posedge Mclk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    tx_buf_d      = tx_buf_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    rx_data_d     = rx_data_q;
    rx_done_d     = 1'b0;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    word_load     = 1'b0;
    tx_accept     = tx_valid & ~tx_full_q;

    if (rx_done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          word_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DSIZE-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DSIZE - 1)) rx_done_d = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_q == CNT_W'(DSIZE)) word_load = 1'b1;
          else tx_shift_d = {tx_shift_q[DSIZE-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    // The shift register always sees the buffer as it was before this cycle's tx load.
    if (word_load) begin
      bit_cnt_d = '0;
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
      end else begin
        tx_shift_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end

    tx_full_d = (tx_full_q & ~word_load) | tx_accept;
    if (tx_accept) tx_buf_d = tx_data;
  end

  always_ff @(posedge Mclk or posedge reset) begin
    if (reset) begin
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      rx_done_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_done_q     <= rx_done_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign busy         = (state_q == ACTIVE);
  assign spi_miso_oe  = busy;
  assign spi_miso_out = busy & tx_shift_q[DSIZE-1];
  assign tx_ready     = ~tx_full_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_underrun  = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a vector table of single-word transfers
// plus hand-written burst, abort and reset-mid-transfer sequences.
module tb_spi_slave_rx;

  logic       Mclk, reset, spi_clk, spi_cs, spi_mosi_in;
  logic       spi_miso_out, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, busy;

  spi_slave_rx #(.DSIZE(8), .CNT_W(4)) dut (
    .Mclk(Mclk), .reset(reset), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi_in(spi_mosi_in), .spi_miso_out(spi_miso_out),
    .spi_miso_oe(spi_miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  initial Mclk = 1'b0;
  always #5 Mclk = ~Mclk;

  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  always @(posedge Mclk) begin
    #1;
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = rx_data;
    end
    if (tx_underrun) ur_cnt = ur_cnt + 1;
  end

  typedef struct {
    logic [7:0] tx;
    logic       pre;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_ur;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Mclk);
  endtask

  task automatic load_tx(input logic [7:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  // Mode 0 master, SPI half period = 4 Mclk; MISO sampled just before each rise.
  task automatic xfer(input logic [7:0] w, input int nbits, input logic ld_en,
                      input logic [7:0] ld_w, output logic [7:0] miso_w);
    miso_w = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi_in = w[i];
      if (ld_en && i == 4) begin
        load_tx(ld_w);
        cyc(3);
      end else begin
        cyc(4);
      end
      miso_w[i] = spi_miso_out;
      spi_clk = 1'b1;
      cyc(4);
      spi_clk = 1'b0;
    end
  endtask

  logic [7:0] m, m2;
  int rx0, ur0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[1] = '{8'h00, 1'b0, 8'h81, 8'h00, 8'h81, 1};
    vecs[2] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vecs[3] = '{8'h5A, 1'b1, 8'hC7, 8'h5A, 8'hC7, 0};

    reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi_in = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    cyc(3);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_miso", spi_miso_out, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    reset = 1'b0;
    cyc(3);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].pre) begin
        load_tx(vecs[v].tx);
        chk("tbl_ready_full", tx_ready, 0);
      end
      rx0 = rx_cnt; ur0 = ur_cnt;
      spi_cs = 1'b0;
      cyc(8);
      chk("tbl_underrun_csfall", ur_cnt - ur0, vecs[v].exp_ur);
      chk("tbl_ready_after_csfall", tx_ready, 1);
      chk("tbl_busy", busy, 1);
      chk("tbl_oe", spi_miso_oe, 1);
      xfer(vecs[v].mosi, 8, 1'b0, 8'h00, m);
      cyc(6);
      spi_cs = 1'b1;
      cyc(6);
      chk("tbl_miso", m, vecs[v].exp_miso);
      chk("tbl_rx_pulses", rx_cnt - rx0, 1);
      chk("tbl_rx_data", rx_last, vecs[v].exp_rx);
      chk("tbl_idle", busy, 0);
    end

    // Burst: two words under one cs, second tx word loaded mid-word.
    load_tx(8'h11);
    rx0 = rx_cnt;
    spi_cs = 1'b0;
    cyc(8);
    xfer(8'hF0, 8, 1'b1, 8'h22, m);
    cyc(2);
    chk("burst_rx1_pulses", rx_cnt - rx0, 1);
    chk("burst_rx1_data", rx_last, 8'hF0);
    xfer(8'h0F, 8, 1'b0, 8'h00, m2);
    cyc(6);
    spi_cs = 1'b1;
    cyc(6);
    chk("burst_miso1", m, 8'h11);
    chk("burst_miso2", m2, 8'h22);
    chk("burst_rx_pulses", rx_cnt - rx0, 2);
    chk("burst_rx2_data", rx_last, 8'h0F);

    // Abort after 5 bits, then a clean word.
    rx0 = rx_cnt;
    spi_cs = 1'b0;
    cyc(8);
    xfer(8'hFF, 5, 1'b0, 8'h00, m);
    cyc(4);
    spi_cs = 1'b1;
    cyc(8);
    chk("abort_no_rx", rx_cnt - rx0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_oe", spi_miso_oe, 0);
    spi_cs = 1'b0;
    cyc(8);
    xfer(8'h55, 8, 1'b0, 8'h00, m);
    cyc(6);
    spi_cs = 1'b1;
    cyc(6);
    chk("after_abort_rx_pulses", rx_cnt - rx0, 1);
    chk("after_abort_rx_data", rx_last, 8'h55);

    // Reset asserted between clock edges at bit 4 of a transfer.
    load_tx(8'h3E);
    spi_cs = 1'b0;
    cyc(8);
    load_tx(8'h77);
    chk("pre_rst_ready", tx_ready, 0);
    xfer(8'hC3, 4, 1'b0, 8'h00, m);
    spi_clk = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_oe", spi_miso_oe, 0);
    chk("async_rst_miso", spi_miso_out, 0);
    chk("async_rst_ready", tx_ready, 1);
    chk("async_rst_rx_valid", rx_valid, 0);
    chk("async_rst_underrun", tx_underrun, 0);
    chk("async_rst_rx_data", rx_data, 0);
    spi_clk = 1'b0;
    spi_cs = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    rx0 = rx_cnt;
    spi_cs = 1'b0;
    cyc(8);
    chk("post_rst_busy", busy, 1);
    xfer(8'hC3, 8, 1'b0, 8'h00, m);
    cyc(6);
    spi_cs = 1'b1;
    cyc(6);
    chk("post_rst_rx_pulses", rx_cnt - rx0, 1);
    chk("post_rst_rx_data", rx_last, 8'hC3);
    chk("post_rst_miso", m, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
